// File: rtl/cpu_datapath_pkg.sv
// Shared constants for the single-bus CPU datapath: ALU op codes,
// register load-enable bit positions and bus-source select positions.
// Optional feature macro: CPU_DATAPATH_MULDIV_EN (signed MUL/DIV in the ALU).
package cpu_datapath_pkg;

  localparam int DATA_W = 32;

  // ALU op codes (Control_Signals)
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_ROR = 4'd6;
  localparam logic [3:0] ALU_ROL = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;
  localparam logic [3:0] ALU_NEG = 4'd10;
  localparam logic [3:0] ALU_NOT = 4'd11;

  // Load-enable bit positions (enable bus); R0..R15 occupy bits 0..15
  localparam int EN_R0      = 0;
  localparam int EN_R1      = 1;
  localparam int EN_R2      = 2;
  localparam int EN_R3      = 3;
  localparam int EN_R15     = 15;
  localparam int EN_OUTPORT = 17;
  localparam int EN_HI      = 18;
  localparam int EN_LO      = 19;
  localparam int EN_PC      = 20;
  localparam int EN_MDR     = 21;
  localparam int EN_IR      = 23;
  localparam int EN_Z       = 24;
  localparam int EN_MAR     = 25;
  localparam int EN_Y       = 27;
  localparam int EN_INCPC   = 28;

  // Bus-source select positions (busSelect); R0..R15 occupy bits 0..15
  localparam int SEL_R0     = 0;
  localparam int SEL_R1     = 1;
  localparam int SEL_R2     = 2;
  localparam int SEL_R3     = 3;
  localparam int SEL_R15    = 15;
  localparam int SEL_HI     = 16;
  localparam int SEL_LO     = 17;
  localparam int SEL_ZHI    = 18;
  localparam int SEL_ZLO    = 19;
  localparam int SEL_PC     = 20;
  localparam int SEL_MDR    = 21;
  localparam int SEL_INPORT = 22;
  localparam int NUM_SRC    = 23;

  localparam int NUM_GPR    = 16;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the single-bus datapath. A comes from Y, B from the bus.
// Produces a 64-bit result written into Z (ZHI:ZLO).
// Optional feature macro: CPU_DATAPATH_MULDIV_EN enables signed MUL and DIV;
// without it ops 8 and 9 return 0 and no multiplier/divider exists.
module cpu_alu
  import cpu_datapath_pkg::*;
(
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  input  logic [3:0]          i_op,
  input  logic                i_incpc,
  output logic [2*DATA_W-1:0] o_result
);

  logic [4:0] w_shamt;
  logic [5:0] w_shamt_inv;

  assign w_shamt     = i_b[4:0];
  // Complementary amount for rotates; a shift by 32 yields 0, so count 0 is safe.
  assign w_shamt_inv = 6'd32 - {1'b0, w_shamt};

`ifdef CPU_DATAPATH_MULDIV_EN
  logic signed [2*DATA_W-1:0] w_prod;
  logic        [DATA_W-1:0]   w_quot;
  logic        [DATA_W-1:0]   w_rem;

  assign w_prod = $signed({{DATA_W{i_a[DATA_W-1]}}, i_a}) *
                  $signed({{DATA_W{i_b[DATA_W-1]}}, i_b});

  // Signed divide; a zero divisor returns all-ones quotient and the dividend as remainder.
  always_comb begin
    w_quot = '1;
    w_rem  = i_a;
    if (i_b != '0) begin
      w_quot = $signed(i_a) / $signed(i_b);
      w_rem  = $signed(i_a) % $signed(i_b);
    end
  end
`endif

  // Result select: PC increment overrides the op code; 32-bit ops zero-extend into the upper half.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    o_result = '0;
    if (i_incpc) begin
      o_result = {{DATA_W{1'b0}}, i_b + 32'd1};
    end else begin
      case (i_op)
        ALU_ADD: o_result = {{DATA_W{1'b0}}, i_a + i_b};
        ALU_SUB: o_result = {{DATA_W{1'b0}}, i_a - i_b};
        ALU_OR:  o_result = {{DATA_W{1'b0}}, i_a | i_b};
        ALU_AND: o_result = {{DATA_W{1'b0}}, i_a & i_b};
        ALU_SHR: o_result = {{DATA_W{1'b0}}, i_a >> w_shamt};
        ALU_SHL: o_result = {{DATA_W{1'b0}}, i_a << w_shamt};
        ALU_ROR: o_result = {{DATA_W{1'b0}}, (i_a >> w_shamt) | (i_a << w_shamt_inv)};
        ALU_ROL: o_result = {{DATA_W{1'b0}}, (i_a << w_shamt) | (i_a >> w_shamt_inv)};
`ifdef CPU_DATAPATH_MULDIV_EN
        ALU_MUL: o_result = w_prod;
        ALU_DIV: o_result = {w_rem, w_quot};
`endif
        ALU_NEG: o_result = {{DATA_W{1'b0}}, 32'd0 - i_b};
        ALU_NOT: o_result = {{DATA_W{1'b0}}, ~i_b};
        default: o_result = '0;
      endcase
    end
  end

endmodule

// File: rtl/cpu_datapath.sv
// 32-bit single-bus CPU datapath: R0-R15, PC, IR, MAR, MDR, HI, LO, Y and a
// 64-bit Z around cpu_alu. An external control unit drives one-hot bus
// selects, load enables and the ALU op code. Lowest set select bit wins the bus.
// Optional feature macro: CPU_DATAPATH_MULDIV_EN (passed through to cpu_alu).
module cpu_datapath
  import cpu_datapath_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      enable,
  input  logic [31:0]      busSelect,
  input  logic [WIDTH-1:0] inPort,
  input  logic [WIDTH-1:0] MDataIn,
  input  logic             MD_Read,
  input  logic             IncPC,
  input  logic [3:0]       Control_Signals,
  output logic [WIDTH-1:0] busMuxOut,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] mdr,
  output logic [WIDTH-1:0] zhi,
  output logic [WIDTH-1:0] zlo,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] temp
);

  logic [WIDTH-1:0]   r_gpr [NUM_GPR];
  logic [WIDTH-1:0]   r_pc;
  logic [WIDTH-1:0]   r_ir;
  logic [WIDTH-1:0]   r_mar;
  logic [WIDTH-1:0]   r_mdr;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_y;
  logic [2*WIDTH-1:0] r_z;

  logic [WIDTH-1:0]   w_src [NUM_SRC];
  logic [WIDTH-1:0]   w_bus;
  logic [2*WIDTH-1:0] w_alu_result;
  logic               w_incpc;

  // Gather every bus source into one array indexed by its select bit.
  always_comb begin
    for (int i = 0; i < NUM_GPR; i++) begin
      w_src[i] = r_gpr[i];
    end
    w_src[SEL_HI]     = r_hi;
    w_src[SEL_LO]     = r_lo;
    w_src[SEL_ZHI]    = r_z[2*WIDTH-1:WIDTH];
    w_src[SEL_ZLO]    = r_z[WIDTH-1:0];
    w_src[SEL_PC]     = r_pc;
    w_src[SEL_MDR]    = r_mdr;
    w_src[SEL_INPORT] = inPort;
  end

  // Priority bus mux: scanning high to low lets the lowest set select bit win; idle bus is 0.
  always_comb begin
    w_bus = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (busSelect[i]) w_bus = w_src[i];
    end
  end

  assign w_incpc = IncPC | enable[EN_INCPC];

  cpu_alu u_alu (
    .i_a      (r_y),
    .i_b      (w_bus),
    .i_op     (Control_Signals),
    .i_incpc  (w_incpc),
    .o_result (w_alu_result)
  );

  // General-purpose registers R0-R15, each loading the bus on its own enable.
  always_ff @(posedge clk or posedge clr) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (clr) begin
      // NOTE: the register file is small and architecturally must read 0 after reset, so it is cleared element by element.
      for (int i = 0; i < NUM_GPR; i++) begin
        r_gpr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (enable[EN_R0 + i]) r_gpr[i] <= w_bus;
      end
    end
  end

  // Special-purpose registers that load straight from the bus.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_mar <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_y   <= '0;
    end else begin
      if (enable[EN_PC])  r_pc  <= w_bus;
      if (enable[EN_IR])  r_ir  <= w_bus;
      if (enable[EN_MAR]) r_mar <= w_bus;
      if (enable[EN_HI])  r_hi  <= w_bus;
      if (enable[EN_LO])  r_lo  <= w_bus;
      if (enable[EN_Y])   r_y   <= w_bus;
    end
  end

  // MDR takes memory read data or the bus, chosen by MD_Read.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_mdr <= '0;
    end else if (enable[EN_MDR]) begin
      r_mdr <= MD_Read ? MDataIn : w_bus;
    end
  end

  // Z captures the full 64-bit ALU result.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_z <= '0;
    end else if (enable[EN_Z]) begin
      r_z <= w_alu_result;
    end
  end

  assign busMuxOut = w_bus;
  assign r1        = r_gpr[1];
  assign r2        = r_gpr[2];
  assign r3        = r_gpr[3];
  assign mdr       = r_mdr;
  assign zhi       = r_z[2*WIDTH-1:WIDTH];
  assign zlo       = r_z[WIDTH-1:0];
  assign pc        = r_pc;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign temp      = r_y;

  // IR and MAR are loaded for the control unit and memory side but have no
  // observation port here; reserved enable/select bits are deliberately ignored.
  logic w_unused;
  assign w_unused = ^{enable[31:29], enable[26], enable[22], enable[17:16],
                      busSelect[31:23], r_ir, r_mar};

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed sequences for reset, MDR,
// AND, PC increment and bus priority; a table of ALU vectors; and randomized
// ALU operations checked against an arithmetic reference model.
module tb_cpu_datapath;
  import cpu_datapath_pkg::*;

`ifdef CPU_DATAPATH_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] enable, busSelect, inPort, MDataIn;
  logic        MD_Read, IncPC;
  logic [3:0]  Control_Signals;
  logic [31:0] busMuxOut, r1, r2, r3, mdr, zhi, zlo, pc, hi, lo, temp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cpu_datapath dut (
    .clk             (clk),
    .clr             (clr),
    .enable          (enable),
    .busSelect       (busSelect),
    .inPort          (inPort),
    .MDataIn         (MDataIn),
    .MD_Read         (MD_Read),
    .IncPC           (IncPC),
    .Control_Signals (Control_Signals),
    .busMuxOut       (busMuxOut),
    .r1              (r1),
    .r2              (r2),
    .r3              (r3),
    .mdr             (mdr),
    .zhi             (zhi),
    .zlo             (zlo),
    .pc              (pc),
    .hi              (hi),
    .lo              (lo),
    .temp            (temp)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        inc;
    logic [63:0] exp;
  } alu_vec_t;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] bit32(input int idx);
    return 32'(1) << idx;
  endfunction

  // Reference ALU written from the arithmetic rules, not from the RTL structure.
  function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input logic inc);
    logic [31:0] x;
    int          sa, sb, n;
    longint      p;
    sa = a;
    sb = b;
    n  = int'(b) & 31;
    if (inc) return {32'd0, b + 32'd1};
    case (op)
      4'd0: return {32'd0, 32'(longint'(a) + longint'(b))};
      4'd1: return {32'd0, 32'(longint'(a) - longint'(b))};
      4'd2: return {32'd0, a | b};
      4'd3: return {32'd0, a & b};
      4'd4: begin
        x = a;
        for (int k = 0; k < n; k++) x = x / 2;
        return {32'd0, x};
      end
      4'd5: begin
        x = a;
        for (int k = 0; k < n; k++) x = x * 2;
        return {32'd0, x};
      end
      4'd6: begin
        x = a;
        for (int k = 0; k < n; k++) x = {x[0], x[31:1]};
        return {32'd0, x};
      end
      4'd7: begin
        x = a;
        for (int k = 0; k < n; k++) x = {x[30:0], x[31]};
        return {32'd0, x};
      end
      4'd8: begin
        if (!MULDIV) return 64'd0;
        p = longint'(sa) * longint'(sb);
        return p;
      end
      4'd9: begin
        if (!MULDIV) return 64'd0;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      4'd10: return {32'd0, 32'(-sb)};
      4'd11: return {32'd0, ~b};
      default: return 64'd0;
    endcase
  endfunction

  task automatic idle_inputs();
    enable = '0; busSelect = '0; inPort = '0; MDataIn = '0;
    MD_Read = 1'b0; IncPC = 1'b0; Control_Signals = '0;
  endtask

  // One control step: drive selects/enables, take one rising edge, sample 1 ns later.
  task automatic cycle(input logic [31:0] sel, input logic [31:0] en, input logic [3:0] op);
    busSelect = sel; enable = en; Control_Signals = op;
    @(posedge clk); #1;
    busSelect = '0; enable = '0; Control_Signals = '0;
  endtask

  task automatic load_mdr(input logic [31:0] val);
    MDataIn = val; MD_Read = 1'b1;
    cycle('0, bit32(EN_MDR), ALU_ADD);
    MD_Read = 1'b0;
  endtask

  task automatic load_reg(input int en_idx, input logic [31:0] val);
    load_mdr(val);
    cycle(bit32(SEL_MDR), bit32(en_idx), ALU_ADD);
  endtask

  // Y <- a, then bus = b through MDR with Zin; result lands in Z.
  task automatic alu_run(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic inc);
    load_reg(EN_Y, a);
    load_mdr(b);
    IncPC = inc;
    cycle(bit32(SEL_MDR), bit32(EN_Z), op);
    IncPC = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " r1"},   r1,   0);
    check({tag, " r2"},   r2,   0);
    check({tag, " r3"},   r3,   0);
    check({tag, " mdr"},  mdr,  0);
    check({tag, " zhi"},  zhi,  0);
    check({tag, " zlo"},  zlo,  0);
    check({tag, " pc"},   pc,   0);
    check({tag, " hi"},   hi,   0);
    check({tag, " lo"},   lo,   0);
    check({tag, " temp"}, temp, 0);
  endtask

  alu_vec_t vecs [20];

  initial begin
    logic [31:0] a, b;
    logic [3:0]  op;
    logic        inc;
    logic [63:0] exp;

    vecs[0]  = '{"add wrap",    32'hFFFF_FFFF, 32'h1,          ALU_ADD, 1'b0, 64'h0};
    vecs[1]  = '{"sub neg",     32'd3,         32'd5,          ALU_SUB, 1'b0, 64'h0000_0000_FFFF_FFFE};
    vecs[2]  = '{"or",          32'hF0,        32'h0F,         ALU_OR,  1'b0, 64'hFF};
    vecs[3]  = '{"and",         32'hFF00_FF00, 32'h0FF0_0FF0,  ALU_AND, 1'b0, 64'h0F00_0F00};
    vecs[4]  = '{"shr logical", 32'h8000_0000, 32'd4,          ALU_SHR, 1'b0, 64'h0800_0000};
    vecs[5]  = '{"shl 31",      32'h1,         32'd31,         ALU_SHL, 1'b0, 64'h8000_0000};
    vecs[6]  = '{"shr cnt b40", 32'h8,         32'h21,         ALU_SHR, 1'b0, 64'h4};
    vecs[7]  = '{"ror 1",       32'h1,         32'd1,          ALU_ROR, 1'b0, 64'h8000_0000};
    vecs[8]  = '{"rol 4",       32'h8000_0001, 32'd4,          ALU_ROL, 1'b0, 64'h18};
    vecs[9]  = '{"ror 0",       32'h1234_5678, 32'd0,          ALU_ROR, 1'b0, 64'h1234_5678};
    vecs[10] = '{"mul -3*4",    32'hFFFF_FFFD, 32'd4,          ALU_MUL, 1'b0, 64'hFFFF_FFFF_FFFF_FFF4};
    vecs[11] = '{"mul max",     32'h7FFF_FFFF, 32'h7FFF_FFFF,  ALU_MUL, 1'b0, 64'h3FFF_FFFF_0000_0001};
    vecs[12] = '{"div 17/5",    32'd17,        32'd5,          ALU_DIV, 1'b0, 64'h0000_0002_0000_0003};
    vecs[13] = '{"div -17/5",   32'hFFFF_FFEF, 32'd5,          ALU_DIV, 1'b0, 64'hFFFF_FFFE_FFFF_FFFD};
    vecs[14] = '{"div by 0",    32'h1234,      32'd0,          ALU_DIV, 1'b0, 64'h0000_1234_FFFF_FFFF};
    vecs[15] = '{"neg 1",       32'h55,        32'd1,          ALU_NEG, 1'b0, 64'hFFFF_FFFF};
    vecs[16] = '{"not 0",       32'h55,        32'd0,          ALU_NOT, 1'b0, 64'hFFFF_FFFF};
    vecs[17] = '{"op 12",       32'h55,        32'h66,         4'd12,   1'b0, 64'h0};
    vecs[18] = '{"op 15",       32'h55,        32'h66,         4'd15,   1'b0, 64'h0};
    vecs[19] = '{"incpc wrap",  32'h55,        32'hFFFF_FFFF,  ALU_SUB, 1'b1, 64'h0};

    idle_inputs();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    clr = 1'b0;

    // Async clear without a clock edge, and bus still live during clear.
    load_reg(EN_R1, 32'd7);
    check("r1 load 7", r1, 32'd7);
    clr = 1'b1;
    #1;
    check_all_zero("async clr");
    inPort = 32'h1234; busSelect = bit32(SEL_INPORT);
    #1;
    check("bus during clr", busMuxOut, 32'h1234);
    busSelect = '0; inPort = '0;
    @(posedge clk); #1;
    clr = 1'b0;

    // MDR from memory, then to R2.
    load_mdr(32'd5);
    check("mdr mem load", mdr, 32'd5);
    cycle(bit32(SEL_MDR), bit32(EN_R2), ALU_ADD);
    check("r2 from mdr", r2, 32'd5);

    // AND sequence.
    load_reg(EN_R3, 32'd6);
    check("r3 load 6", r3, 32'd6);
    cycle(bit32(SEL_R2), bit32(EN_Y), ALU_ADD);
    check("y from r2", temp, 32'd5);
    cycle(bit32(SEL_R3), bit32(EN_Z), ALU_AND);
    check("and zlo", zlo, 32'd4);
    check("and zhi", zhi, 32'd0);
    cycle(bit32(SEL_ZLO), bit32(EN_R1), ALU_ADD);
    check("r1 from zlo", r1, 32'd4);

    // PC increment via enable[28], then via the IncPC port.
    load_reg(EN_PC, 32'h10);
    check("pc load", pc, 32'h10);
    cycle(bit32(SEL_PC), bit32(EN_INCPC) | bit32(EN_Z), ALU_AND);
    check("incpc zlo", zlo, 32'h11);
    cycle(bit32(SEL_ZLO), bit32(EN_PC), ALU_ADD);
    check("pc inc", pc, 32'h11);
    IncPC = 1'b1;
    cycle(bit32(SEL_PC), bit32(EN_Z), ALU_SUB);
    IncPC = 1'b0;
    check("incpc port zlo", zlo, 32'h12);

    // Bus priority and idle.
    busSelect = bit32(SEL_R2) | bit32(SEL_R3);
    #1;
    check("bus prio r2", busMuxOut, 32'd5);
    busSelect = bit32(SEL_R3) | bit32(SEL_INPORT); inPort = 32'hABCD;
    #1;
    check("bus prio r3", busMuxOut, 32'd6);
    busSelect = '0;
    #1;
    check("bus idle", busMuxOut, 32'd0);
    busSelect = bit32(SEL_INPORT);
    #1;
    check("bus inport", busMuxOut, 32'hABCD);
    busSelect = 32'hFF80_0000;
    #1;
    check("bus high bits", busMuxOut, 32'd0);
    busSelect = '0;
    @(posedge clk); #1;

    // Multiple loads in one cycle, and R0 as an ordinary register.
    inPort = 32'h55;
    cycle(bit32(SEL_INPORT), bit32(EN_HI) | bit32(EN_LO) | bit32(EN_R3) | bit32(EN_R0), ALU_ADD);
    check("multi hi", hi, 32'h55);
    check("multi lo", lo, 32'h55);
    check("multi r3", r3, 32'h55);
    inPort = '0;
    cycle(bit32(SEL_R0), bit32(EN_R1), ALU_ADD);
    check("r0 to r1", r1, 32'h55);
    cycle(bit32(SEL_LO), bit32(EN_R2), ALU_ADD);
    check("lo to r2", r2, 32'h55);

    // Table-driven ALU vectors.
    for (int i = 0; i < 20; i++) begin
      exp = vecs[i].exp;
      if (!MULDIV && (vecs[i].op == ALU_MUL || vecs[i].op == ALU_DIV)) exp = 64'd0;
      alu_run(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].inc);
      check(vecs[i].name, {zhi, zlo}, exp);
    end

    // Randomized ALU operations against the reference model, plus Z drained to R1/HI.
    for (int i = 0; i < 60; i++) begin
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      op  = 4'($urandom_range(0, 15));
      inc = ($urandom_range(0, 7) == 0);
      if (op == ALU_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      exp = ref_alu(a, b, op, inc);
      alu_run(a, b, op, inc);
      check($sformatf("rand%0d op%0d z", i, op), {zhi, zlo}, exp);
      cycle(bit32(SEL_ZLO), bit32(EN_R1), ALU_ADD);
      cycle(bit32(SEL_ZHI), bit32(EN_HI), ALU_ADD);
      check($sformatf("rand%0d r1", i), r1, exp[31:0]);
      check($sformatf("rand%0d hi", i), hi, exp[63:32]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- 32-bit single-bus CPU datapath: 16 GPRs (R0–R15), PC, IR, MAR, MDR, HI, LO, Y and a 64-bit Z (ZHI/ZLO) register around an ALU.
- External control-step logic drives one-hot bus-source selects (`busSelect`), register load enables (`enable`) and the ALU op code.
- Sits between the control unit and memory; key registers are exposed for observation.

Parameters:
- `WIDTH`, 32, data/bus width (fixed at 32 in this revision).

Ports:
- `clk`  in  1  system clock; all registers update on rising edge.
- `clr`  in  1  asynchronous, active-high reset.
- `enable`  in  32  register load enables.
  - [15:0] R0–R15in; [16] unused; [17] OutPortin (unused); [18] HIin; [19] LOin; [20] PCin; [21] MDRin.
  - [22] unused; [23] IRin; [24] Zin; [25] MARin; [26] unused; [27] Yin; [28] IncPC; [31:29] unused.
- `busSelect`  in  32  bus-source selects.
  - [15:0] R0–R15out; [16] HIout; [17] LOout; [18] ZHIout; [19] ZLOout; [20] PCout; [21] MDRout; [22] InPortout; [31:23] unused.
- `inPort`  in  32  external input-port data.
- `MDataIn`  in  32  memory read data.
- `MD_Read`  in  1  MDR input mux: 1 = `MDataIn`, 0 = bus.
- `IncPC`  in  1  OR'd with `enable[28]`; must be driven (tie 0 if unused).
- `Control_Signals`  in  4  ALU op code.
- `busMuxOut`  out  32  current bus value.
- `r1`, `r2`, `r3`  out  32  contents of R1, R2, R3.
- `mdr`  out  32  MDR contents.
- `zhi`, `zlo`  out  32  Z[63:32], Z[31:0].
- `pc`, `hi`, `lo`  out  32  PC, HI, LO contents.
- `temp`  out  32  Y register contents.

Behaviour:
- Reset: `clr`=1 asynchronously clears every register (R0–R15, PC, IR, MAR, MDR, HI, LO, Y, Z) to 0. All register outputs read 0 while `clr` is high.
- Bus (combinational):
  - Bus = source selected by the lowest-index set `busSelect` bit in [22:0].
  - No bit set → bus = 0. Bits [31:23] are ignored.
- Register writes: on `posedge clk`, each register with its enable high loads the bus. Exceptions:
  - MDR loads `MD_Read ? MDataIn : bus`.
  - Z loads the 64-bit ALU result.
  - Several registers may load in the same cycle.
- R0 is an ordinary writable register.
- ALU operands: A = Y, B = bus. B shift count = B[4:0].
- If `IncPC` or `enable[28]` is high, the result is {32'b0, bus+1} regardless of op.
- Otherwise, by `Control_Signals`:
  - 0 ADD; 1 SUB (A−B); 2 OR; 3 AND.
  - 4 SHR (logical); 5 SHL; 6 ROR; 7 ROL.
  - 8 MUL (signed, 64-bit); 9 DIV (signed: Z[31:0] = quotient, Z[63:32] = remainder).
  - 10 NEG (−B); 11 NOT (~B); 12–15 → 0.
- Result width: non-MUL/DIV results are zero-extended into Z[63:32]. Add/sub wrap mod 2^32.
- DIV by zero: quotient = 32'hFFFFFFFF, remainder = A.
- Latency: ALU is combinational; the result appears in Z one edge after Zin, and on the bus the cycle after that via ZLOout.
- Reset mid-operation: all state is lost; the bus still reflects inputs combinationally.

Optional Feature:
- Macro: `CPU_DATAPATH_MULDIV_EN`.
- Defined: MUL (8) and DIV (9) are implemented as above.
- Undefined: ops 8 and 9 produce Z = 0 and no multiplier/divider is synthesised.

Decomposition:
- Shared package `cpu_datapath_pkg` holds:
  - ALU op-code constants (`ALU_ADD` … `ALU_NOT`);
  - `enable` bit-index constants (`EN_R0` … `EN_INCPC`);
  - `busSelect` index constants (`SEL_R0` … `SEL_INPORT`).
- One sub-module: `cpu_alu` (combinational; inputs A, B, op, incpc; output 64-bit result).
- Register file and bus mux stay in the top.

Test Plan:
- Reset: assert `clr` after loading R1 = 7 → all outputs 0 immediately, without a clock edge.
- Register load via MDR:
  - `MDataIn` = 5, `MD_Read` = 1, `enable[21]` for one edge → `mdr` = 5.
  - Then `busSelect[21]`, `enable[2]` → `r2` = 5.
- AND sequence:
  - Setup: R2 = 5, R3 = 6.
  - `busSelect[2]` + `enable[27]` → `temp` = 5.
  - `busSelect[3]` + op 3 + `enable[24]` → `zlo` = 4, `zhi` = 0.
  - `busSelect[19]` + `enable[1]` → `r1` = 4.
- PC increment: PC = 0x10; `busSelect[20]` + `enable[28]` + `enable[24]` → `zlo` = 0x11. Then ZLOout + PCin → `pc` = 0x11.
- MUL/DIV (macro defined):
  - Y = −3, bus = 4, op 8 → {`zhi`, `zlo`} = 64'hFFFFFFFF_FFFFFFF4.
  - Y = 17, bus = 5, op 9 → `zlo` = 3, `zhi` = 2.
  - Macro undefined → Z = 0 for both ops.
- Bus priority/idle:
  - `busSelect[2]` and `busSelect[3]` both set → bus = R2.
  - `busSelect` = 0 → `busMuxOut` = 0.
  - `busSelect[22]` with `inPort` = 0xABCD → bus = 0xABCD.
